// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, registered in_ready and a
// one-entry skid register, with bubble-forcing of control fields and a flush-kill counter.
module pipe_stage_elastic #(
  parameter int CW         = 16,
  parameter int DW         = 96,
  parameter int CLEAR_DATA = 0,
  parameter int KW         = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ctrl,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_ctrl,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy,
  output logic [KW-1:0] kill_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] main_ctrl;
  logic [DW-1:0] main_data;
  logic [CW-1:0] skid_ctrl;
  logic [DW-1:0] skid_data;

  logic          push;
  logic          pop;
  logic [KW:0]   kill_sum;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = main_data;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // One extra bit catches overflow so the counter saturates instead of wrapping.
  assign kill_sum = {1'b0, kill_count}
                  + {{(KW-1){1'b0}}, occupancy}
                  + {{KW{1'b0}}, push};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
      kill_count <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLEAR_DATA != 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
      kill_count <= kill_sum[KW] ? {KW{1'b1}} : kill_sum[KW-1:0];
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (push && !pop) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
            state     <= FULL;
            in_ready  <= 1'b0;
          end else if (push && pop) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (pop) begin
            main_ctrl <= '0;
            if (CLEAR_DATA != 0) main_data <= '0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
            skid_ctrl <= '0;
            if (CLEAR_DATA != 0) skid_data <= '0;
            state    <= BUSY;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: two instances (hold-data/wide counter and
// clear-data/2-bit counter) share stimulus and are compared against a FIFO model.
module tb_pipe_stage_elastic;

  localparam int CW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;
  logic [7:0]    kill0;
  logic [1:0]    kill1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.CW(CW), .DW(DW), .CLEAR_DATA(0), .KW(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occ0), .kill_count(kill0)
  );

  pipe_stage_elastic #(.CW(CW), .DW(DW), .CLEAR_DATA(1), .KW(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .occupancy(occ1), .kill_count(kill1)
  );

  // Reference: a FIFO of at most two entries plus the kill tallies.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  int            mkill0 = 0;
  int            mkill1 = 0;
  logic [DW-1:0] held0 = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      mkill0 = 0;
      mkill1 = 0;
      held0  = '0;
    end else begin
      bit   acc;
      bit   take;
      ent_t e;
      acc  = in_valid && (q.size() < 2);
      take = out_ready && (q.size() > 0);
      e.c  = in_ctrl;
      e.d  = in_data;
      if (flush) begin
        mkill0 = mkill0 + q.size() + int'(acc);
        mkill1 = mkill1 + q.size() + int'(acc);
        if (mkill0 > 255) mkill0 = 255;
        if (mkill1 > 3)   mkill1 = 3;
        q.delete();
      end else begin
        if (take) void'(q.pop_front());
        if (acc)  q.push_back(e);
      end
      if (q.size() > 0) held0 = q[0].d;
    end
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(bit v, logic [CW-1:0] c, logic [DW-1:0] d, bit ordy, bit fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Every cycle: both instances against the model.
  always @(negedge clk) begin
    bit            ne;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    ne = (q.size() > 0);
    ec = ne ? q[0].c : '0;
    ed = ne ? q[0].d : '0;
    checkOutput("out_valid0", 32'(out_valid0), 32'(ne));
    checkOutput("in_ready0",  32'(in_ready0),  32'(q.size() < 2));
    checkOutput("occ0",       32'(occ0),       32'(q.size()));
    checkOutput("out_ctrl0",  32'(out_ctrl0),  32'(ec));
    checkOutput("out_data0",  32'(out_data0),  32'(ne ? ed : held0));
    checkOutput("kill0",      32'(kill0),      32'(mkill0));
    checkOutput("out_valid1", 32'(out_valid1), 32'(ne));
    checkOutput("in_ready1",  32'(in_ready1),  32'(q.size() < 2));
    checkOutput("occ1",       32'(occ1),       32'(q.size()));
    checkOutput("out_ctrl1",  32'(out_ctrl1),  32'(ec));
    checkOutput("out_data1",  32'(out_data1),  32'(ed));
    checkOutput("kill1",      32'(kill1),      32'(mkill1));
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 8'(i + 8'h40), 16'(i), 1'b1, 1'b0);
      @(negedge clk);
      checkOutput("stream_data", 32'(out_data0), 32'(i));
      checkOutput("stream_occ",  32'(occ0), 32'd1);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);

    // Skid absorbs B when out_ready drops
    applyStimulus(1'b1, 8'hA1, 16'h000A, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'hB2, 16'h000B, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ab_occ_full",   32'(occ0), 32'd2);
    checkOutput("ab_inrdy_full", 32'(in_ready0), 32'd0);
    checkOutput("ab_first_a",    32'(out_data0), 32'h000A);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ab_then_b",     32'(out_data0), 32'h000B);
    checkOutput("ab_ctrl_b",     32'(out_ctrl0), 32'hB2);
    checkOutput("ab_inrdy_back", 32'(in_ready0), 32'd1);
    @(negedge clk);
    checkOutput("ab_empty", 32'(out_valid0), 32'd0);

    // Flush from FULL with C offered: two entries killed, C refused
    applyStimulus(1'b1, 8'h11, 16'h0011, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h22, 16'h0022, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'hCC, 16'h0CCC, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("fl_valid", 32'(out_valid0), 32'd0);
    checkOutput("fl_ctrl",  32'(out_ctrl0), 32'd0);
    checkOutput("fl_kill0", 32'(kill0), 32'd2);
    checkOutput("fl_kill1", 32'(kill1), 32'd2);
    checkOutput("fl_inrdy", 32'(in_ready0), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("fl_no_c", 32'(out_valid0), 32'd0);

    // Second two-entry flush saturates the 2-bit counter
    applyStimulus(1'b1, 8'h33, 16'h0033, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h44, 16'h0044, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("sat_kill0", 32'(kill0), 32'd4);
    checkOutput("sat_kill1", 32'(kill1), 32'd3);

    // Flush in BUSY with a same-cycle push: both counted
    applyStimulus(1'b1, 8'h55, 16'h0055, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h66, 16'h0066, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("push_kill0", 32'(kill0), 32'd6);
    checkOutput("push_kill1", 32'(kill1), 32'd3);

    // Data field after popping to empty
    applyStimulus(1'b1, 8'h5A, 16'h0ABC, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("hold_data0",  32'(out_data0), 32'h0ABC);
    checkOutput("clear_data1", 32'(out_data1), 32'h0000);
    checkOutput("hold_ctrl0",  32'(out_ctrl0), 32'd0);
    checkOutput("clear_ctrl1", 32'(out_ctrl1), 32'd0);

    // Asynchronous reset while FULL, observed before any edge
    applyStimulus(1'b1, 8'h71, 16'h0071, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h72, 16'h0072, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(out_valid0), 32'd0);
    checkOutput("rst_occ",   32'(occ0), 32'd0);
    checkOutput("rst_inrdy", 32'(in_ready0), 32'd1);
    checkOutput("rst_ctrl",  32'(out_ctrl0), 32'd0);
    checkOutput("rst_data",  32'(out_data0), 32'd0);
    checkOutput("rst_kill",  32'(kill0), 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 8'h77, 16'h0777, 1'b1, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_valid", 32'(out_valid0), 32'd1);
    checkOutput("rel_data",  32'(out_data0), 32'h0777);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(99) < 70), 8'($urandom), 16'($urandom),
                    ($urandom_range(99) < 60), ($urandom_range(99) < 5));
      @(negedge clk);
    end

    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
